// File: rtl/bresenham_line_engine.sv
// bresenham_line_engine
// Rasterises one line segment (x0,y0)->(x1,y1) into a stream of pixel
// coordinates, one per clock, with integer Bresenham stepping in all octants.
// Optional feature macro: BRESENHAM_LINE_CLIP_EN. When defined, pixel_valid is
// suppressed for pixels outside H_RES x V_RES; stepping and timing are unchanged.
//
// Handshake: start is a request sampled only while IDLE; it is accepted on the
// edge where it is seen high in IDLE. busy is high from the cycle after
// acceptance through the done cycle. done is a one-cycle pulse after the last
// pixel. Requests while busy are dropped, never queued.
module bresenham_line_engine #(
    parameter int WIDTH = 11,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             pixel_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg_o
);

    // Error-term width: holds dx, -dy and their sums without overflow.
    localparam int EW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q;

    // Captured endpoints (held for the whole line).
    logic [WIDTH-1:0] x0_q, y0_q, x1_q, y1_q;

    // Stepping state.
    logic signed [EW-1:0] dx_q, dy_q, err_q;
    logic                 sx_pos_q, sy_pos_q;
    logic [WIDTH-1:0]     x_q, y_q;
    logic                 pv_q, busy_q, done_q;

    // Setup-phase combinational results.
    logic signed [EW-1:0] adx_d, ady_d, dy_d, err_setup_d;

    // Draw-phase combinational results.
    logic signed [EW:0]   e2_d, dx_ext_d, dy_ext_d;
    logic                 step_x_d, step_y_d, at_end_d;
    logic signed [EW-1:0] err_d;
    logic [WIDTH-1:0]     x_d, y_d;
    logic                 pv_setup_d, pv_step_d;

    // Absolute deltas and initial error term from the captured endpoints.
    always_comb begin
        if (x0_q < x1_q) adx_d = $signed({2'b00, x1_q}) - $signed({2'b00, x0_q});
        else             adx_d = $signed({2'b00, x0_q}) - $signed({2'b00, x1_q});
        if (y0_q < y1_q) ady_d = $signed({2'b00, y1_q}) - $signed({2'b00, y0_q});
        else             ady_d = $signed({2'b00, y0_q}) - $signed({2'b00, y1_q});
        dy_d        = -ady_d;
        err_setup_d = adx_d - ady_d;
    end

    // One Bresenham step: decide x/y moves from e2 and accumulate both terms.
    always_comb begin
        e2_d     = {err_q, 1'b0};
        dx_ext_d = {dx_q[EW-1], dx_q};
        dy_ext_d = {dy_q[EW-1], dy_q};
        step_x_d = (e2_d >= dy_ext_d);
        step_y_d = (e2_d <= dx_ext_d);
        at_end_d = (x_q == x1_q) && (y_q == y1_q);

        err_d = err_q;
        x_d   = x_q;
        y_d   = y_q;
        if (step_x_d) begin
            err_d = err_d + dy_q;
            x_d   = sx_pos_q ? (x_q + WIDTH'(1)) : (x_q - WIDTH'(1));
        end
        if (step_y_d) begin
            err_d = err_d + dx_q;
            y_d   = sy_pos_q ? (y_q + WIDTH'(1)) : (y_q - WIDTH'(1));
        end
    end

`ifdef BRESENHAM_LINE_CLIP_EN
    localparam logic [WIDTH:0] H_LIM = (WIDTH + 1)'(H_RES);
    localparam logic [WIDTH:0] V_LIM = (WIDTH + 1)'(V_RES);

    // On-screen test for the pixel that will be presented next cycle.
    always_comb begin
        pv_setup_d = ({1'b0, x0_q} < H_LIM) && ({1'b0, y0_q} < V_LIM);
        pv_step_d  = ({1'b0, x_d}  < H_LIM) && ({1'b0, y_d}  < V_LIM);
    end
`else
    // Every drawn pixel is written; range handling belongs to the framebuffer.
    always_comb begin
        pv_setup_d = 1'b1;
        pv_step_d  = 1'b1;
    end

    // Resolution parameters only matter with clipping; keep them referenced.
    if (H_RES < 1 || V_RES < 1) begin : g_res_unused
    end
`endif

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_pos_q <= 1'b0;
            sy_pos_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            pv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pv_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        x0_q    <= x0;
                        y0_q    <= y0;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    dx_q     <= adx_d;
                    dy_q     <= dy_d;
                    err_q    <= err_setup_d;
                    sx_pos_q <= (x0_q < x1_q);
                    sy_pos_q <= (y0_q < y1_q);
                    x_q      <= x0_q;
                    y_q      <= y0_q;
                    pv_q     <= pv_setup_d;
                    state_q  <= S_DRAW;
                end
                S_DRAW: begin
                    if (at_end_d) begin
                        pv_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        err_q <= err_d;
                        x_q   <= x_d;
                        y_q   <= y_d;
                        pv_q  <= pv_step_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    pv_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_valid = pv_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_dbg_o = state_q;

endmodule

// File: doc/bresenham_line_engine.md
# bresenham_line_engine

Rasterises one straight line segment between two pixel endpoints into a stream of (x, y) pixel coordinates, one per clock, using integer Bresenham stepping in all eight octants. Sits directly upstream of `VGA_framebuffer`. Its `x`/`y`/`pixel_valid` outputs drive the framebuffer's coordinate and write inputs, through the top-level clear/draw mux. An animation controller supplies the endpoints and a `start` strobe, and watches `busy`/`done`.

## Interface
Parameters:
- `WIDTH`, 11, coordinate width in bits (unsigned).
- `H_RES`, 640, visible columns; used only under `LINE_CLIP_EN`.
- `V_RES`, 480, visible rows; used only under `LINE_CLIP_EN`.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain). One clock only.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new line; sampled only in IDLE.
- `x0`, `y0`  in  WIDTH  start endpoint.
- `x1`, `y1`  in  WIDTH  end endpoint.
- `x`, `y`  out  WIDTH  current pixel coordinate (registered).
- `pixel_valid`  out  1  `x`/`y` hold a pixel to write this cycle.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` is high, inclusive.
- `done`  out  1  one-cycle pulse after the last pixel.

## Operation
- Reset values: state IDLE, `x`=0, `y`=0, `pixel_valid`=0, `busy`=0, `done`=0, internal error term 0.
- FSM states are IDLE, SETUP, DRAW, DONE.
- IDLE -> SETUP when `start`=1. Endpoints are captured on that edge. Later input changes are ignored until the next accepted `start`.
- SETUP runs for one cycle and computes the following:
  - dx = |x1−x0|; dy = −|y1−y0|.
  - sx = +1 if x0<x1, else −1; sy = +1 if y0<y1, else −1.
  - err = dx+dy.
  - Load `x`=x0, `y`=y0.
  - Go to DRAW.
- DRAW, each cycle:
  - Present (`x`,`y`) with `pixel_valid`=1.
  - If `x`==x1 and `y`==y1, go to DONE.
  - Otherwise compute e2 = 2·err, then apply both of the following:
    - if e2 ≥ dy, then err += dy and `x` += sx;
    - if e2 ≤ dx, then err += dx and `y` += sy.
  - Both conditions may fire in the same cycle (diagonal step); the err update is the sum of both terms.
- DONE: `done`=1 and `pixel_valid`=0 for one cycle, then IDLE.
- Arithmetic widths:
  - dx, dy and err are signed, WIDTH+2 bits.
  - e2 is signed, WIDTH+3 bits.
  - Coordinates never wrap, because the endpoint test terminates stepping.
- Pixel count per line is max(dx, |dy|)+1, in plotting order from (x0,y0) to (x1,y1) inclusive.
- Degenerate line (x0==x1 and y0==y1): exactly one pixel.
- `start` while `busy` is ignored; no queuing.
- `start` held high across DONE→IDLE starts a new line on the IDLE cycle.
- `reset` mid-line: the next cycle is IDLE with all outputs at reset values, and no `done` is produced.

## Timing
- Let cycle 0 be the edge on which `start` is sampled in IDLE.
- Cycle 1: SETUP; `busy`=1; `pixel_valid`=0.
- Cycles 2 … N+1: DRAW, one pixel per cycle, where N is the pixel count.
- Cycle N+2: DONE; `done`=1 and `busy`=1.
- Cycle N+3: IDLE; `busy`=0.
- Latency from `start` to first pixel is 2 cycles. Total occupancy is N+3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `BRESENHAM_LINE_CLIP_EN`.
- Defined:
  - During DRAW, `pixel_valid` = (`x` < H_RES) && (`y` < V_RES).
  - Stepping, cycle count and `done` timing are unchanged.
  - Off-screen pixels are skipped, never clamped.
- Undefined:
  - `pixel_valid`=1 on every DRAW cycle regardless of coordinate.
  - The framebuffer is responsible for out-of-range writes.
  - `H_RES`/`V_RES` are unused.

## Test plan
- Horizontal line (0,0)→(4,0) with `start` at cycle 0:
  - pixels (0,0)…(4,0) in cycles 2–6;
  - `done` at cycle 7;
  - `busy` low at cycle 8.
- Steep reverse line (10,10)→(8,4):
  - 7 pixels: (10,10),(10,9),(9,8),(9,7),(9,6),(8,5),(8,4);
  - `y` decrements every DRAW cycle;
  - last pixel is exactly (8,4).
- Degenerate line (5,5)→(5,5):
  - single pixel (5,5) at cycle 2;
  - `done` at cycle 3.
- Start while busy:
  - second `start` with different endpoints pulsed at cycle 3 of the line (0,0)→(4,0);
  - first line completes unchanged and the second request is not executed.
- Reset mid-draw:
  - assert `reset` at cycle 4 of (0,0)→(20,7);
  - next cycle `pixel_valid`=0, `busy`=0, `x`=`y`=0, and `done` never pulses.
- Clipping, with `BRESENHAM_LINE_CLIP_EN` defined, line (630,0)→(645,0):
  - 16 DRAW cycles;
  - `pixel_valid` high for x=630…639 only;
  - `done` at cycle 18.
  - With the macro undefined: all 16 pixels valid.
